// File: rtl/usb_rx_byte_assembler.sv
// usb_rx_byte_assembler: LSB-first USB Rx byte assembler with SYNC strip and EOP framing; define USB_RX_SYNC_CHECK_EN to require SYNC==0x80
module usb_rx_byte_assembler #(
  parameter int MAX_BYTES = 64
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           d_orig,
  input  logic                           shift_enable,
  input  logic                           shift_stop,
  input  logic                           rx_start,
  input  logic                           eop,
  output logic [7:0]                     rx_data,
  output logic                           byte_ready,
  output logic                           rx_active,
  output logic                           rx_done,
  output logic                           rx_error,
  output logic [$clog2(MAX_BYTES+1)-1:0] byte_count
);
  localparam int CW = $clog2(MAX_BYTES+1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BYTES);
  typedef enum logic [2:0] {IDLE, SYNC, DATA, DONE, ERROR} state_t;
  state_t state;
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic acc, last, sync_ok;
  logic [7:0] nb;
  assign acc = shift_enable & ~shift_stop;
  assign last = acc && bit_cnt == 3'd7;
  assign nb = {d_orig, sr[7:1]};
  assign rx_active = state == SYNC || state == DATA;
  assign rx_done = state == DONE;
`ifdef USB_RX_SYNC_CHECK_EN
  assign sync_ok = nb == 8'h80;
`else
  assign sync_ok = 1'b1;
`endif
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      sr <= '0;
      bit_cnt <= '0;
      rx_data <= '0;
      byte_ready <= 1'b0;
      rx_error <= 1'b0;
      byte_count <= '0;
    end else begin
      byte_ready <= 1'b0;
      case (state)
        IDLE, ERROR: if (rx_start) begin
          state <= SYNC;
          sr <= '0;
          bit_cnt <= '0;
          byte_count <= '0;
          rx_error <= 1'b0;
        end
        SYNC: if (eop) begin
          state <= ERROR;
          rx_error <= 1'b1;
        end else if (acc) begin
          sr <= nb;
          bit_cnt <= bit_cnt + 3'd1;
          if (last) begin
            state <= sync_ok ? DATA : ERROR;
            rx_error <= ~sync_ok;
          end
        end
        DATA: if (eop) begin
          state <= bit_cnt == 3'd0 ? DONE : ERROR;
          rx_error <= rx_error | (bit_cnt != 3'd0);
        end else if (acc) begin
          sr <= nb;
          bit_cnt <= bit_cnt + 3'd1;
          if (last && byte_count < MAXC) begin
            rx_data <= nb;
            byte_ready <= 1'b1;
            byte_count <= byte_count + 1'b1;
          end else if (last) rx_error <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_rx_byte_assembler.sv
// tb_usb_rx_byte_assembler: table and random packet checks for usb_rx_byte_assembler (MAX_BYTES=4)
module tb_usb_rx_byte_assembler;
  localparam int MB = 4;
  localparam int CW = $clog2(MB+1);
`ifdef USB_RX_SYNC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, n_rst = 1'b0, d_orig = 1'b0, shift_enable = 1'b0, shift_stop = 1'b0, rx_start = 1'b0, eop = 1'b0;
  logic [7:0] rx_data;
  logic byte_ready, rx_active, rx_done, rx_error;
  logic [CW-1:0] byte_count;
  int n_chk = 0, n_fail = 0, ones = 0, done_seen = 0;
  logic [7:0] obs[$];
  typedef struct {
    logic [7:0] sync;
    int n;
    logic [7:0] d [6];
    int extra;
    int rdy;
    int cnt;
    bit done;
    bit err;
  } vec_t;
  vec_t vt [7];
  usb_rx_byte_assembler #(.MAX_BYTES(MB)) dut (
    .clk(clk), .n_rst(n_rst), .d_orig(d_orig), .shift_enable(shift_enable),
    .shift_stop(shift_stop), .rx_start(rx_start), .eop(eop), .rx_data(rx_data),
    .byte_ready(byte_ready), .rx_active(rx_active), .rx_done(rx_done),
    .rx_error(rx_error), .byte_count(byte_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (byte_ready) obs.push_back(rx_data);
    if (rx_done) done_seen++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic strobe_stuffed(input logic b);
    d_orig = b;
    shift_enable = 1'b1;
    shift_stop = 1'b1;
    tick();
    shift_enable = 1'b0;
    shift_stop = 1'b0;
  endtask
  task automatic send_bit(input logic b);
    if ($urandom_range(0, 4) == 0) strobe_stuffed(1'($urandom));
    if ($urandom_range(0, 4) == 0) begin
      shift_stop = 1'b1;
      tick();
      shift_stop = 1'b0;
    end
    d_orig = b;
    shift_enable = 1'b1;
    tick();
    shift_enable = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      strobe_stuffed(1'b0);
      ones = 0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask
  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask
  task automatic start_pkt(input string nm);
    rx_start = 1'b1;
    tick();
    rx_start = 1'b0;
    ones = 0;
    chk({nm, "_active"}, 32'(rx_active), 1);
  endtask
  function automatic void model(input logic [7:0] sync, input int n, input int extra,
                                output int rdy, output bit done, output bit err);
    if (CHK && sync != 8'h80) begin
      rdy = 0;
      done = 1'b0;
      err = 1'b1;
    end else begin
      rdy = n < MB ? n : MB;
      done = extra == 0;
      err = n > MB || extra != 0;
    end
  endfunction
  task automatic run_check(input string nm, input logic [7:0] sync, input int n, input logic [7:0] d [6],
                           input int extra, input int rdy, input int cnt, input bit done, input bit err);
    int o0, dn0;
    o0 = obs.size();
    dn0 = done_seen;
    start_pkt(nm);
    send_byte(sync);
    for (int i = 0; i < n; i++) send_byte(d[i]);
    for (int i = 0; i < extra; i++) send_bit(1'($urandom));
    eop = 1'b1;
    tick();
    eop = 1'b0;
    repeat (4) tick();
    chk({nm, "_nbytes"}, obs.size() - o0, rdy);
    for (int i = 0; i < rdy && o0 + i < obs.size(); i++) chk({nm, "_data"}, 32'(obs[o0+i]), 32'(d[i]));
    chk({nm, "_count"}, 32'(byte_count), cnt);
    chk({nm, "_done"}, done_seen - dn0, 32'(done));
    chk({nm, "_error"}, 32'(rx_error), 32'(err));
    chk({nm, "_idle"}, 32'(rx_active), 0);
  endtask
  initial begin
    int o0, dn0;
    vt[0] = '{8'h80, 2, '{8'hA5, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 2, 2, 1'b1, 1'b0};
    vt[1] = '{8'h80, 1, '{8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 1, 1, 1'b1, 1'b0};
    if (CHK) vt[2] = '{8'h81, 2, '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 0, 1'b0, 1'b1};
    else vt[2] = '{8'h81, 2, '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 2, 2, 1'b1, 1'b0};
    vt[3] = '{8'h80, 1, '{8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 1, 1, 1'b0, 1'b1};
    vt[4] = '{8'h80, 5, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00}, 0, 4, 4, 1'b1, 1'b1};
    vt[5] = '{8'h80, 0, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 0, 1'b1, 1'b0};
    vt[6] = '{8'h80, 2, '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 2, 2, 1'b1, 1'b0};
    repeat (3) tick();
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_ready", 32'(byte_ready), 0);
    chk("rst_active", 32'(rx_active), 0);
    chk("rst_done", 32'(rx_done), 0);
    chk("rst_error", 32'(rx_error), 0);
    chk("rst_count", 32'(byte_count), 0);
    n_rst = 1'b1;
    tick();
    for (int k = 0; k < 7; k++)
      run_check($sformatf("vec%0d", k), vt[k].sync, vt[k].n, vt[k].d, vt[k].extra,
                vt[k].rdy, vt[k].cnt, vt[k].done, vt[k].err);
    run_check("partial", vt[3].sync, vt[3].n, vt[3].d, vt[3].extra, vt[3].rdy, vt[3].cnt, vt[3].done, vt[3].err);
    start_pkt("restart");
    chk("restart_error", 32'(rx_error), 0);
    chk("restart_count", 32'(byte_count), 0);
    dn0 = done_seen;
    send_byte(8'h80);
    eop = 1'b1;
    tick();
    eop = 1'b0;
    repeat (3) tick();
    chk("restart_done", done_seen - dn0, 1);
    dn0 = done_seen;
    start_pkt("eopsync");
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    eop = 1'b1;
    tick();
    eop = 1'b0;
    repeat (3) tick();
    chk("eopsync_error", 32'(rx_error), 1);
    chk("eopsync_active", 32'(rx_active), 0);
    chk("eopsync_done", done_seen - dn0, 0);
    o0 = obs.size();
    dn0 = done_seen;
    start_pkt("collide");
    send_byte(8'h80);
    send_byte(8'h5A);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    d_orig = 1'b0;
    shift_enable = 1'b1;
    eop = 1'b1;
    tick();
    shift_enable = 1'b0;
    eop = 1'b0;
    repeat (3) tick();
    chk("collide_nbytes", obs.size() - o0, 1);
    if (obs.size() > o0) chk("collide_data", 32'(obs[o0]), 32'h5A);
    chk("collide_count", 32'(byte_count), 1);
    chk("collide_error", 32'(rx_error), 1);
    chk("collide_done", done_seen - dn0, 0);
    chk("collide_active", 32'(rx_active), 0);
    for (int k = 0; k < 40; k++) begin
      logic [7:0] s, d [6];
      int n, ex, rdy;
      bit dn, er;
      s = $urandom_range(0, 1) == 1 ? 8'h80 : 8'($urandom);
      n = $urandom_range(0, 6);
      ex = $urandom_range(0, 3) == 0 ? $urandom_range(1, 7) : 0;
      foreach (d[j]) d[j] = 8'($urandom);
      model(s, n, ex, rdy, dn, er);
      run_check($sformatf("rand%0d", k), s, n, d, ex, rdy, rdy, dn, er);
    end
    start_pkt("midrst");
    send_byte(8'h80);
    send_byte(8'hC3);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    n_rst = 1'b0;
    #2;
    chk("midrst_data", 32'(rx_data), 0);
    chk("midrst_ready", 32'(byte_ready), 0);
    chk("midrst_active", 32'(rx_active), 0);
    chk("midrst_done", 32'(rx_done), 0);
    chk("midrst_error", 32'(rx_error), 0);
    chk("midrst_count", 32'(byte_count), 0);
    tick();
    n_rst = 1'b1;
    tick();
    run_check("post_rst", vt[0].sync, vt[0].n, vt[0].d, vt[0].extra, vt[0].rdy, vt[0].cnt, vt[0].done, vt[0].err);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
